rca_pipelined: RTL and testbench
================================

Name: rca_pipelined

Overview:
- Parametrised, pipelined successor to the 8-bit structural ripple-carry adder.
- Splits a WIDTH-bit carry chain into STAGES registered segments. Each segment is a ripple chunk of CHUNK = WIDTH/STAGES bits.
- Adds add/subtract mode, signed-overflow flag and a valid/ready handshake with backpressure.
- Sits in the datapath as the team's standard multi-cycle adder, replacing wide single-cycle ripple chains that miss timing.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline segments; WIDTH mod STAGES must be 0. Illegal combinations are caught by an elaboration-time check.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: A+B+cin; 1: A−B, computed as A+~B+1.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH−1. In sub mode, 1 means no borrow.
- ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - The payload on a, b, cin and sub is sampled only on a transfer.
- Global stall enable: en = ~out_valid | out_ready; in_ready = en, combinational.
  - When en=0, every pipeline register, including its valid bit, holds.
  - No bubble collapsing.
- Stage k (0..STAGES−1):
  - Ripple-adds chunk k of A and chunk k of B' (B' = sub ? ~b : b).
  - Carry-in for stage 0 is (sub ? 1 : cin). For k>0 it is the carry registered by stage k−1.
  - Registers its sum chunk, its carry out, and a valid bit.
- Operand skew: unused upper chunks of A and B' are carried forward in delay registers alongside their stage. Completed lower sum chunks are carried forward so all chunks of one beat emerge together.
- Operand handling:
  - B inversion happens once, at input capture.
  - The sub bit itself is not needed downstream.
- Final stage: additionally registers cout and ovf. ovf uses the carry into bit WIDTH−1 from inside the last chunk.
- Latency:
  - A beat accepted at rising edge t appears with out_valid=1 after edge t+STAGES−1, i.e. STAGES cycles from acceptance to visible output, with no stalls.
  - Each stall cycle adds one cycle.
  - Throughput is 1 beat/cycle while out_ready=1.
- STAGES=1: a single ripple of WIDTH bits into the output register; latency 1.
- Output stability: while out_valid=1 & out_ready=0, sum, cout and ovf are held stable.
- Simultaneous events: with out_valid=1 and out_ready=1, a new input is accepted in the same cycle the output leaves. There is no lost or duplicated beat.
- Arithmetic is modulo 2^WIDTH; cout carries the extra bit.
- Reset:
  - All valid bits clear; sum=0, cout=0, ovf=0, out_valid=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight beats; no partial result is ever presented.
  - rst has priority over en.
- Data registers may hold stale values when their valid bit is 0. Outputs, however, read 0 only after reset, not after every drain.

Test Plan (WIDTH=32, STAGES=4 unless noted):
- Latency check:
  - Stimulus: single beat a=0x0000_0001, b=0xFFFF_FFFF, cin=0, sub=0, out_ready=1.
  - Required: out_valid rises exactly 4 cycles later; sum=0x0000_0000, cout=1, ovf=0. Verifies carry crossing every stage boundary.
- Signed overflow and subtract:
  - Stimulus: a=0x7FFF_FFFF, b=0x0000_0001, sub=0.
  - Required: sum=0x8000_0000, cout=0, ovf=1.
  - Stimulus: then a=0x0000_0005, b=0x0000_0007, sub=1, cin=1 (cin ignored).
  - Required: sum=0xFFFF_FFFE, cout=0, ovf=0.
- Backpressure:
  - Stimulus: stream 8 back-to-back random beats; hold out_ready=0 for 3 cycles mid-stream.
  - Required: in_ready=0 exactly while out_valid=1 & out_ready=0. Results match the reference model in order, with none lost or duplicated, and sum is held stable during the stall.
- Reset mid-operation:
  - Stimulus: accept 3 beats, assert rst for 1 cycle before any emerges.
  - Required: out_valid stays 0 thereafter until new beats are sent; outputs read 0; the next beat returns the correct result after 4 cycles.
- Degenerate parameters:
  - Stimulus: WIDTH=8, STAGES=1, a=0xFF, b=0x01, cin=1.
  - Required: sum=0x01, cout=1, latency 1.
  - Stimulus: WIDTH=8, STAGES=8, same operands.
  - Required: identical result, latency 8.
- Random regression: 10,000 beats with random out_ready and in_valid; scoreboard against {cout,sum} = a + B' + cin0 and the ovf formula.

Source files
------------

// File: rtl/rca_pipelined.sv
// Pipelined ripple-carry adder/subtractor with a valid/ready handshake.
// WIDTH bits are split into STAGES registered ripple segments.
module rca_pipelined #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NS    = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK = WIDTH / NS;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % NS) != 0) begin : g_param_chk
    $error("rca_pipelined: illegal WIDTH/STAGES combination");
  end

  function automatic logic [CHUNK:0] ripple(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             ci
  );
    logic             c;
    logic [CHUNK-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  logic             en;
  logic [NS-1:0]    v_q, v_d;
  logic [NS-1:0]    c_q, c_d;
  logic [WIDTH-1:0] a_q [NS];
  logic [WIDTH-1:0] a_d [NS];
  logic [WIDTH-1:0] b_q [NS];
  logic [WIDTH-1:0] b_d [NS];
  logic [WIDTH-1:0] s_q [NS];
  logic [WIDTH-1:0] s_d [NS];
  logic             ovf_q, ovf_d;

  logic             src_v, src_c;
  logic [WIDTH-1:0] src_a, src_b, src_s;
  logic [CHUNK:0]   r;

  always_comb begin
    en    = ~v_q[NS-1] | out_ready;
    v_d   = v_q;
    c_d   = c_q;
    a_d   = a_q;
    b_d   = b_q;
    s_d   = s_q;
    ovf_d = ovf_q;
    src_v = 1'b0;
    src_c = 1'b0;
    src_a = '0;
    src_b = '0;
    src_s = '0;
    r     = '0;
    for (int k = 0; k < NS; k++) begin
      if (k == 0) begin
        src_v = in_valid;
        src_a = a;
        src_b = sub ? ~b : b;
        src_s = '0;
        src_c = sub | cin;
      end else begin
        src_v = v_q[k-1];
        src_a = a_q[k-1];
        src_b = b_q[k-1];
        src_s = s_q[k-1];
        src_c = c_q[k-1];
      end
      r = ripple(src_a[k*CHUNK +: CHUNK],
                 src_b[k*CHUNK +: CHUNK], src_c);
      // data registers load only with a live beat
      if (en) begin
        v_d[k] = src_v;
        if (src_v) begin
          a_d[k] = src_a;
          b_d[k] = src_b;
          s_d[k] = src_s;
          s_d[k][k*CHUNK +: CHUNK] = r[CHUNK-1:0];
          c_d[k] = r[CHUNK];
          if (k == NS-1)
            ovf_d = r[CHUNK] ^ s_d[k][WIDTH-1]
                  ^ src_a[WIDTH-1] ^ src_b[WIDTH-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NS; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
    end
  end

  assign in_ready  = en;
  assign out_valid = v_q[NS-1];
  assign sum       = s_q[NS-1];
  assign cout      = c_q[NS-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_pipelined.sv
// Bench for rca_pipelined: directed table, corner sequences,
// random regression against an arithmetic scoreboard.
module tb_rca_pipelined;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout, ovf;

  logic [7:0]  a8 = '0, b8 = '0;
  logic        cin8 = 1'b0, iv8 = 1'b0;
  logic        ir1, ir8, ov1, ov8, c1, c8, o1, o8;
  logic [7:0]  s1, s8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rca_pipelined #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  rca_pipelined #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir1),
    .a(a8), .b(b8), .cin(cin8), .sub(1'b0), .out_valid(ov1),
    .out_ready(1'b1), .sum(s1), .cout(c1), .ovf(o1)
  );

  rca_pipelined #(.WIDTH(8), .STAGES(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(cin8), .sub(1'b0), .out_valid(ov8),
    .out_ready(1'b1), .sum(s8), .cout(c8), .ovf(o8)
  );

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
  } res_t;

  // Reference: unsigned and signed arithmetic on wide integers
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic sb);
    res_t   r;
    longint ux, uy, us, sx, sy, sr;
    ux = {32'b0, x};
    uy = {32'b0, y};
    sx = $signed(x);
    sy = $signed(y);
    if (sb) begin
      us  = ux - uy;
      sr  = sx - sy;
      r.c = (ux >= uy);
    end else begin
      us  = ux + uy + {63'b0, ci};
      sr  = sx + sy + {63'b0, ci};
      r.c = us[32];
    end
    r.s = us[31:0];
    r.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return r;
  endfunction

  res_t exp_q[$];
  int   n_in = 0, n_out = 0;
  logic prev_stall = 1'b0;
  res_t prev_out;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", {63'b0, in_ready}, {63'b0, (!out_valid || out_ready)});
      if (prev_stall) begin
        chk("stall_hold", {31'b0, sum, cout, ovf}, {31'b0, prev_out});
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          chk("sb_result", {31'b0, sum, cout, ovf}, {31'b0, exp_q.pop_front()});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = '{s: sum, c: cout, o: ovf};
    end
  end

  typedef struct {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] s;
    logic        c, o;
  } vec_t;

  vec_t vecs[6];

  task automatic send_one(input string nm, input logic [31:0] va,
                          input logic [31:0] vb, input logic vc,
                          input logic vs, input logic [31:0] es,
                          input logic ec, input logic eo);
    int n;
    in_valid = 1'b1;
    a = va; b = vb; cin = vc; sub = vs;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_lat"}, 64'(n), 64'd4);
    chk({nm, "_sum"}, {32'b0, sum}, {32'b0, es});
    chk({nm, "_cout"}, {63'b0, cout}, {63'b0, ec});
    chk({nm, "_ovf"}, {63'b0, ovf}, {63'b0, eo});
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  // mode 0: all beats valid, 3-cycle output stall; mode 1: random both sides
  task automatic stream(input int nbeats, input int mode, input int budget);
    int sent, cyc;
    sent = 0;
    cyc  = 0;
    while (sent < nbeats && cyc < budget) begin
      in_valid = (mode == 0) ? 1'b1 : ($urandom_range(3) != 0);
      a   = $urandom;
      b   = $urandom;
      cin = $urandom_range(1);
      sub = $urandom_range(1);
      if (mode == 0) out_ready = !(cyc >= 3 && cyc < 6);
      else out_ready = ($urandom_range(2) != 0);
      @(negedge clk);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("stream_sent", 64'(sent), 64'(nbeats));
  endtask

  initial begin
    int lat1, lat8, n;
    vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_outs", {31'b0, sum, cout, ovf}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

    for (int i = 0; i < 6; i++) begin
      send_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
               vecs[i].sub, vecs[i].s, vecs[i].c, vecs[i].o);
    end

    stream(8, 0, 40);
    drain("bp");

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rst_mid_valid", {63'b0, out_valid}, 64'd0);
      chk("rst_mid_outs", {31'b0, sum, cout, ovf}, 64'd0);
      @(posedge clk); #1;
    end
    send_one("post_rst", 32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0,
             32'h2222_2221, 1'b0, 1'b0);

    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; iv8 = 1'b1;
    chk("small_ready", {62'b0, ir1, ir8}, 64'd3);
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat1 = 0; lat8 = 0; n = 1;
    while ((lat1 == 0 || lat8 == 0) && n < 20) begin
      if (ov1 && lat1 == 0) begin
        lat1 = n;
        chk("w8s1_res", {54'b0, s1, c1, o1}, {54'b0, 8'h01, 1'b1, 1'b0});
      end
      if (ov8 && lat8 == 0) begin
        lat8 = n;
        chk("w8s8_res", {54'b0, s8, c8, o8}, {54'b0, 8'h01, 1'b1, 1'b0});
      end
      @(posedge clk); #1;
      n++;
    end
    chk("w8s1_lat", 64'(lat1), 64'd1);
    chk("w8s8_lat", 64'(lat8), 64'd8);

    n_in = 0; n_out = 0;
    stream(10000, 1, 60000);
    drain("rand");
    chk("rand_count", 64'(n_out), 64'(n_in));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
